// File: rtl/single_led_decoder_if.sv
// Single-wire LED data bus: serial line in, decoded word,
// status pulses and the forwarded line out.
interface single_led_decoder_if;
    logic        DI;
    logic [23:0] data;
    logic        data_valid;
    logic        DO;
    logic        frame_reset;
    logic        err;

    modport master (
        output DI,
        input  data,
        input  data_valid,
        input  DO,
        input  frame_reset,
        input  err
    );

    modport slave (
        input  DI,
        output data,
        output data_valid,
        output DO,
        output frame_reset,
        output err
    );
endinterface

// File: rtl/single_led_decoder.sv
// Pulse-width decoder for one LED in a daisy chain: captures
// 24 bits LSB first, then forwards the line to the next LED.
module single_led_decoder #(
    parameter int MIN_HIGH     = 5,
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 55,
    parameter int RESET_CYCLES = 2500
) (
    input logic                clk,
    input logic                rst_n,
    single_led_decoder_if.slave io
);

    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [LW-1:0] LCNT_MAX = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] LCNT_HIT = LW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        CAPTURE,
        PASS,
        WAIT_RESET
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          s1;
    logic          di_s;
    logic          di_q;
    logic [5:0]    hcnt;
    logic [LW-1:0] lcnt;
    logic [4:0]    idx_q;
    logic [22:0]   shreg;
    logic [23:0]   data_q;
    logic          dv_q;
    logic          err_q;
    logic          fr_q;
    logic          do_q;

    logic rise;
    logic fall;
    logic line_rst;
    logic glitch;
    logic toolong;
    logic bit_v;
    logic cap_fall;
    logic take;
    logic last;
    logic err_d;
    logic dv_d;
    logic fr_d;
    logic do_d;

    assign rise     = di_s & ~di_q;
    assign fall     = ~di_s & di_q;
    assign line_rst = ~di_s && (lcnt == LCNT_HIT);
    assign glitch   = int'(hcnt) < MIN_HIGH;
    assign toolong  = int'(hcnt) > MAX_HIGH;
    assign bit_v    = int'(hcnt) >= BIT_THRESH;
    assign cap_fall = (state_q == CAPTURE) && fall && !line_rst;
    assign take     = cap_fall && !glitch && !toolong;
    assign last     = take && (idx_q == 5'd23);

    // hcnt holds the finished pulse length during the falling-edge cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            di_s <= 1'b0;
            di_q <= 1'b0;
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            s1   <= io.DI;
            di_s <= s1;
            di_q <= di_s;
            if (di_s)
                hcnt <= rise ? 6'd1 : (&hcnt ? hcnt : hcnt + 6'd1);
            if (di_s)
                lcnt <= '0;
            else if (lcnt != LCNT_MAX)
                lcnt <= lcnt + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= CAPTURE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            line_rst:           state_d = CAPTURE;
            last:               state_d = PASS;
            cap_fall & toolong: state_d = WAIT_RESET;
            default:            ;
        endcase
    end

    always_comb begin
        err_d = cap_fall && (glitch || toolong);
        dv_d  = last;
        fr_d  = line_rst;
        do_d  = (state_q == PASS) && di_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            shreg  <= '0;
            data_q <= '0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
            fr_q   <= 1'b0;
            do_q   <= 1'b0;
        end else begin
            dv_q  <= dv_d;
            err_q <= err_d;
            fr_q  <= fr_d;
            do_q  <= do_d;
            if (line_rst || (cap_fall && toolong)) begin
                idx_q <= '0;
                shreg <= '0;
            end else if (last) begin
                data_q <= {bit_v, shreg};
                idx_q  <= '0;
                shreg  <= '0;
            end else if (take) begin
                shreg[idx_q] <= bit_v;
                idx_q        <= idx_q + 5'd1;
            end
        end
    end

    assign io.data        = data_q;
    assign io.data_valid  = dv_q;
    assign io.err         = err_q;
    assign io.frame_reset = fr_q;
    assign io.DO          = do_q;

endmodule

// File: tb/tb_single_led_decoder.sv
// Randomized bench for single_led_decoder with a pulse-level
// reference model of capture, forwarding and line reset.
module tb_single_led_decoder;

    localparam int MINH = 5;
    localparam int THR  = 30;
    localparam int MAXH = 55;
    localparam int RC   = 2500;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    single_led_decoder_if io ();

    single_led_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dv_cnt = 0, err_cnt = 0, fr_cnt = 0, do_cnt = 0;
    logic do_prev = 1'b0;
    int do_rise = 0;

    typedef struct {
        int rise;
        int width;
    } dop_t;
    dop_t exp_do[$];
    dop_t dop_e;

    int mmode = 0;
    logic mbits[$];
    logic [23:0] mdata = '0;
    int exp_dv = 0, exp_err = 0, exp_fr = 0, exp_do_n = 0;
    int mlow = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            do_prev = 1'b0;
        end else begin
            if (io.data_valid) dv_cnt++;
            if (io.err) err_cnt++;
            if (io.frame_reset) fr_cnt++;
            if (io.DO && !do_prev) do_rise = cyc;
            if (!io.DO && do_prev) begin
                do_cnt++;
                checks++;
                if (exp_do.size() == 0) begin
                    errors++;
                    $display("FAIL do_pulse: got pulse at cycle %0d, required none", do_rise);
                end else begin
                    dop_e = exp_do.pop_front();
                    if (do_rise !== dop_e.rise || (cyc - do_rise) !== dop_e.width) begin
                        errors++;
                        $display("FAIL do_pulse: got rise %0d width %0d, required rise %0d width %0d",
                                 do_rise, cyc - do_rise, dop_e.rise, dop_e.width);
                    end
                end
            end
            do_prev = io.DO;
        end
    end

    always @(posedge clk) begin
        if (rst_n && dut.fall && dut.line_rst) begin
            errors++;
            $display("FAIL coincide: falling edge and line reset in cycle %0d", cyc);
        end
    end

    task automatic model_reset();
        mmode = 0;
        mbits.delete();
        mdata = '0;
        mlow = 0;
    endtask

    task automatic low(input int n);
        int old;
        old = mlow;
        mlow = mlow + n;
        if (old < RC && mlow >= RC) begin
            exp_fr++;
            mmode = 0;
            mbits.delete();
        end
        io.DI = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h);
        if (mmode == 1) begin
            exp_do.push_back('{cyc + 3, h});
            exp_do_n++;
        end else if (mmode == 0) begin
            if (h < MINH || h > MAXH) begin
                exp_err++;
                if (h > MAXH) begin
                    mmode = 2;
                    mbits.delete();
                end
            end else begin
                mbits.push_back(h >= THR);
                if (mbits.size() == 24) begin
                    for (int i = 0; i < 24; i++) mdata[i] = mbits[i];
                    exp_dv++;
                    mmode = 1;
                    mbits.delete();
                end
            end
        end
        mlow = 0;
        io.DI = 1'b1;
        repeat (h) @(negedge clk);
        io.DI = 1'b0;
    endtask

    function automatic int rand_h(input logic b);
        return b ? int'($urandom_range(THR, MAXH)) : int'($urandom_range(MINH, THR - 1));
    endfunction

    task automatic send_word(input logic [23:0] w, input bit fixed);
        int h;
        for (int i = 0; i < 24; i++) begin
            h = fixed ? (w[i] ? 40 : 20) : rand_h(w[i]);
            pulse(h);
            low(fixed ? 61 - h : int'($urandom_range(5, 30)));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io.DI = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (io.data !== 24'h0) begin errors++; $display("FAIL rst_data: got %h required 0", io.data); end
        checks++; if (io.data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b required 0", io.data_valid); end
        checks++; if (io.DO !== 1'b0) begin errors++; $display("FAIL rst_do: got %b required 0", io.DO); end
        checks++; if (io.frame_reset !== 1'b0) begin errors++; $display("FAIL rst_fr: got %b required 0", io.frame_reset); end
        checks++; if (io.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", io.err); end
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        low(20);
        send_word(24'hA5C3F1, 1'b1);
        low(10);
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL word_data: got %h required %h", io.data, mdata); end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL word_dv: got %0d required %0d", dv_cnt, exp_dv); end
        checks++; if (do_cnt !== exp_do_n) begin errors++; $display("FAIL word_do: got %0d required %0d", do_cnt, exp_do_n); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL word_err: got %0d required %0d", err_cnt, exp_err); end
    endtask

    task automatic test_pass();
        low(2600);
        send_word(24'h112233, 1'b0);
        send_word(24'h445566, 1'b0);
        low(10);
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL pass_data: got %h required %h", io.data, mdata); end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL pass_dv: got %0d required %0d", dv_cnt, exp_dv); end
        checks++; if (do_cnt !== exp_do_n) begin errors++; $display("FAIL pass_do: got %0d required %0d", do_cnt, exp_do_n); end
        checks++; if (fr_cnt !== exp_fr) begin errors++; $display("FAIL pass_fr: got %0d required %0d", fr_cnt, exp_fr); end
    endtask

    task automatic test_line_reset();
        low(2600);
        for (int i = 0; i < 10; i++) begin
            pulse(rand_h(1'($urandom_range(0, 1))));
            low(int'($urandom_range(5, 30)));
        end
        low(2500);
        low(10);
        checks++; if (fr_cnt !== exp_fr) begin errors++; $display("FAIL lrst_fr: got %0d required %0d", fr_cnt, exp_fr); end
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL lrst_hold: got %h required %h", io.data, mdata); end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL lrst_dv: got %0d required %0d", dv_cnt, exp_dv); end
        send_word(24'h00FF00, 1'b0);
        low(10);
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL lrst_data: got %h required %h", io.data, mdata); end
    endtask

    task automatic test_glitch();
        logic [23:0] w;
        low(2600);
        w = 24'($urandom);
        for (int i = 0; i < 24; i++) begin
            pulse(rand_h(w[i]));
            low(int'($urandom_range(5, 30)));
            if (i == 5) begin
                pulse(3);
                low(10);
            end
        end
        low(10);
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL glitch_data: got %h required %h", io.data, mdata); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL glitch_err: got %0d required %0d", err_cnt, exp_err); end
        low(2600);
        w = 24'($urandom);
        for (int i = 0; i < 24; i++) begin
            pulse(i == 12 ? 60 : rand_h(w[i]));
            low(int'($urandom_range(5, 30)));
        end
        low(10);
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL long_err: got %0d required %0d", err_cnt, exp_err); end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL long_dv: got %0d required %0d", dv_cnt, exp_dv); end
        checks++; if (do_cnt !== exp_do_n) begin errors++; $display("FAIL long_do: got %0d required %0d", do_cnt, exp_do_n); end
        low(2600);
        checks++; if (fr_cnt !== exp_fr) begin errors++; $display("FAIL long_fr: got %0d required %0d", fr_cnt, exp_fr); end
    endtask

    task automatic test_boundary();
        logic [23:0] w;
        int e0, f0;
        low(2600);
        w = 24'($urandom);
        for (int i = 0; i < 24; i++) begin
            pulse(i == 0 ? 29 : i == 1 ? 30 : i == 2 ? 55 : rand_h(w[i]));
            low(int'($urandom_range(5, 30)));
        end
        low(10);
        checks++; if (io.data[2:0] !== 3'b110) begin errors++; $display("FAIL bnd_bits: got %b required 110", io.data[2:0]); end
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL bnd_data: got %h required %h", io.data, mdata); end
        low(2600);
        e0 = err_cnt;
        pulse(56);
        low(10);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bnd_56: got %0d err pulses required 1", err_cnt - e0); end
        f0 = fr_cnt;
        pulse(20);
        low(2499);
        pulse(20);
        low(10);
        checks++; if (fr_cnt - f0 !== 0) begin errors++; $display("FAIL bnd_2499: got %0d resets required 0", fr_cnt - f0); end
        low(2490);
        low(20);
        checks++; if (fr_cnt - f0 !== 1) begin errors++; $display("FAIL bnd_2500: got %0d resets required 1", fr_cnt - f0); end
        checks++; if (fr_cnt !== exp_fr) begin errors++; $display("FAIL bnd_fr: got %0d required %0d", fr_cnt, exp_fr); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            low(2600);
            send_word(24'($urandom), 1'b0);
            for (int j = 0; j < 4; j++) begin
                pulse(int'($urandom_range(1, 60)));
                low(int'($urandom_range(5, 30)));
            end
            low(10);
            checks++; if (io.data !== mdata) begin errors++; $display("FAIL rnd_data: got %h required %h", io.data, mdata); end
            checks++; if (do_cnt !== exp_do_n) begin errors++; $display("FAIL rnd_do: got %0d required %0d", do_cnt, exp_do_n); end
        end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL rnd_dv: got %0d required %0d", dv_cnt, exp_dv); end
    endtask

    task automatic test_reset_mid();
        low(2600);
        for (int i = 0; i < 7; i++) begin
            pulse(rand_h(1'($urandom_range(0, 1))));
            low(int'($urandom_range(5, 30)));
        end
        #3 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        low(20);
        send_word(24'($urandom), 1'b0);
        low(10);
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL mid_data: got %h required %h", io.data, mdata); end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL mid_dv: got %0d required %0d", dv_cnt, exp_dv); end
    endtask

    task automatic test_reset_pass();
        low(2600);
        send_word(24'($urandom), 1'b0);
        low(10);
        io.DI = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (io.DO !== 1'b1) begin errors++; $display("FAIL rp_fwd: got %b required 1", io.DO); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (io.DO !== 1'b0) begin errors++; $display("FAIL rp_do: got %b required 0", io.DO); end
        checks++; if (io.data !== 24'h0) begin errors++; $display("FAIL rp_data: got %h required 0", io.data); end
        checks++; if ({io.data_valid, io.err, io.frame_reset} !== 3'b000) begin
            errors++; $display("FAIL rp_flags: got %b required 000", {io.data_valid, io.err, io.frame_reset});
        end
        io.DI = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        low(20);
        send_word(24'($urandom), 1'b0);
        low(10);
        checks++; if (io.data !== mdata) begin errors++; $display("FAIL rp_word: got %h required %h", io.data, mdata); end
        checks++; if (dv_cnt !== exp_dv) begin errors++; $display("FAIL rp_dv: got %0d required %0d", dv_cnt, exp_dv); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL rp_err: got %0d required %0d", err_cnt, exp_err); end
        checks++; if (fr_cnt !== exp_fr) begin errors++; $display("FAIL rp_fr: got %0d required %0d", fr_cnt, exp_fr); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_pass();
        test_line_reset();
        test_glitch();
        test_boundary();
        test_random();
        test_reset_mid();
        test_reset_pass();
        checks++;
        if (exp_do.size() != 0) begin
            errors++;
            $display("FAIL do_left: got %0d missing pulses required 0", exp_do.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
